// File: rtl/audio_pkg.sv
// Shared constants and the saturating adder used by the sigma-delta modulators.
package audio_pkg;

  localparam int unsigned AUDIO_WIDTH   = 16;
  localparam int unsigned SD_GUARD_BITS = 4;

  typedef logic signed [31:0] sd_wide_t;

  // Adds a + b and clamps the result to the signed range of a 'bits'-wide word (bits <= 30).
  function automatic sd_wide_t sat_add(sd_wide_t a, sd_wide_t b, int unsigned bits);
    sd_wide_t sum;
    sd_wide_t hi;
    sd_wide_t lo;
    sum = a + b;
    hi  = (sd_wide_t'(1) <<< (bits - 1)) - sd_wide_t'(1);
    lo  = -hi - sd_wide_t'(1);
    if (sum > hi) begin
      sat_add = hi;
    end else if (sum < lo) begin
      sat_add = lo;
    end else begin
      sat_add = sum;
    end
  endfunction

endpackage

// File: rtl/audio_sigma_delta_if.sv
// Stereo sample inputs and pulse-density outputs of the sigma-delta DAC.
interface audio_sigma_delta_if #(
  parameter int unsigned WIDTH = 16
);

  logic [WIDTH-1:0] audio_l;
  logic [WIDTH-1:0] audio_r;
  logic             sigma_l;
  logic             sigma_r;

  modport master (
    output audio_l,
    output audio_r,
    input  sigma_l,
    input  sigma_r
  );

  modport slave (
    input  audio_l,
    input  audio_r,
    output sigma_l,
    output sigma_r
  );

endinterface

// File: rtl/sd_channel.sv
// One audio channel: linear interpolator between ticked samples feeding a
// saturating second-order 1-bit sigma-delta modulator.
module sd_channel
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH        = AUDIO_WIDTH,
  parameter int unsigned INTERP_SHIFT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] audio_i,
  output logic             sigma_o
);

  localparam int unsigned CurW = WIDTH + INTERP_SHIFT + 1;
  localparam int unsigned AccW = WIDTH + SD_GUARD_BITS;
  localparam sd_wide_t    Half = sd_wide_t'(1) <<< (WIDTH - 1);

  logic signed [CurW-1:0]  cur_q, cur_d;
  logic signed [WIDTH-1:0] target_q, target_d;
  logic signed [WIDTH:0]   step_q, step_d;
  logic signed [WIDTH-1:0] x;

  logic signed [AccW-1:0]  acc1_q, acc1_d;
  logic signed [AccW-1:0]  acc2_q, acc2_d;
  logic                    out_q, out_d;

  sd_wide_t x_w, fb, a1, a2;

  // The ramp never leaves the WIDTH-bit range, so the top bit of cur is a redundant sign.
  logic unused_cur_msb;
  assign unused_cur_msb = cur_q[CurW-1];

  always_comb begin
    cur_d    = cur_q + {{INTERP_SHIFT{step_q[WIDTH]}}, step_q};
    target_d = target_q;
    step_d   = step_q;
    if (tick_i) begin
      // Snap to the old target so rounding never accumulates across periods.
      cur_d    = {target_q[WIDTH-1], target_q, {INTERP_SHIFT{1'b0}}};
      target_d = audio_i;
      step_d   = {audio_i[WIDTH-1], audio_i} - {target_q[WIDTH-1], target_q};
    end
  end

  assign x = cur_q[INTERP_SHIFT +: WIDTH];

  always_comb begin
    x_w    = sd_wide_t'(x);
    fb     = out_q ? Half : -Half;
    a1     = sat_add(sd_wide_t'(acc1_q), x_w - fb, AccW);
    a2     = sat_add(sd_wide_t'(acc2_q), a1 - fb, AccW);
    acc1_d = a1[AccW-1:0];
    acc2_d = a2[AccW-1:0];
    out_d  = (a2 >= 0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      acc1_q   <= '0;
      acc2_q   <= '0;
      out_q    <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      target_q <= target_d;
      step_q   <= step_d;
      acc1_q   <= acc1_d;
      acc2_q   <= acc2_d;
      out_q    <= out_d;
    end
  end

  assign sigma_o = out_q;

endmodule

// File: rtl/audio_sigma_delta.sv
// Stereo second-order sigma-delta DAC: shared sample tick plus two independent channels.
module audio_sigma_delta
  import audio_pkg::*;
#(
  parameter int unsigned WIDTH        = AUDIO_WIDTH,
  parameter int unsigned INTERP_SHIFT = 8
) (
  input  logic               clk,
  input  logic               reset_in,
  audio_sigma_delta_if.slave bus
);

  logic [INTERP_SHIFT-1:0] cnt_q, cnt_d;
  logic                    tick;

  assign tick = &cnt_q;

  always_comb begin
    cnt_d = cnt_q + INTERP_SHIFT'(1);
  end

  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  sd_channel #(
    .WIDTH       (WIDTH),
    .INTERP_SHIFT(INTERP_SHIFT)
  ) u_ch_l (
    .clk_i  (clk),
    .rst_ni (reset_in),
    .tick_i (tick),
    .audio_i(bus.audio_l),
    .sigma_o(bus.sigma_l)
  );

  sd_channel #(
    .WIDTH       (WIDTH),
    .INTERP_SHIFT(INTERP_SHIFT)
  ) u_ch_r (
    .clk_i  (clk),
    .rst_ni (reset_in),
    .tick_i (tick),
    .audio_i(bus.audio_r),
    .sigma_o(bus.sigma_r)
  );

endmodule

// File: tb/tb_audio_sigma_delta.sv
// Scoreboard bench for audio_sigma_delta: stimulus queues timed expectations,
// a negedge monitor pops and compares them as the DUT reaches each cycle.
module tb_audio_sigma_delta;

  localparam int unsigned W      = 16;
  localparam int unsigned S      = 8;
  localparam int          Per    = 256;
  localparam int          MaxCyc = 40000;

  logic clk      = 1'b0;
  logic reset_in = 1'b0;

  audio_sigma_delta_if #(.WIDTH(W)) bus ();

  audio_sigma_delta #(
    .WIDTH       (W),
    .INTERP_SHIFT(S)
  ) dut (
    .clk     (clk),
    .reset_in(reset_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef enum int {KSigL, KSigR, KOnesL, KOnesR, KXL, KTgtL, KTgtR, KCnt, KTick} kind_e;

  typedef struct {
    int    at;
    kind_e kind;
    int    lo;
    int    hi;
    int    win;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   rel0   = 0;
  int   cum_l[0:MaxCyc];
  int   cum_r[0:MaxCyc];

  function automatic void expect_at(int at, kind_e k, int lo, int hi, string name, int win = 0);
    exp_t e;
    int   i;
    e.at   = at;
    e.kind = k;
    e.lo   = lo;
    e.hi   = hi;
    e.win  = win;
    e.name = name;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endfunction

  // Cycle index at which the monitor will sample the state currently in the registers.
  function automatic int now_c();
    return cyc + 1;
  endfunction

  function automatic int actual(exp_t e);
    case (e.kind)
      KSigL:   return int'(bus.sigma_l);
      KSigR:   return int'(bus.sigma_r);
      KOnesL:  return cum_l[cyc] - cum_l[cyc - e.win];
      KOnesR:  return cum_r[cyc] - cum_r[cyc - e.win];
      KXL:     return int'({16'h0, dut.u_ch_l.x});
      KTgtL:   return int'({16'h0, dut.u_ch_l.target_q});
      KTgtR:   return int'({16'h0, dut.u_ch_r.target_q});
      KCnt:    return int'(dut.cnt_q);
      KTick:   return int'(dut.tick);
      default: return -1;
    endcase
  endfunction

  initial begin
    cum_l[0] = 0;
    cum_r[0] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cum_l[cyc] = cum_l[cyc-1] + int'(bus.sigma_l);
      cum_r[cyc] = cum_r[cyc-1] + int'(bus.sigma_r);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        exp_t e;
        int   a;
        e = sb.pop_front();
        a = actual(e);
        checks++;
        if (a < e.lo || a > e.hi) begin
          errors++;
          $display("FAIL %s @cycle %0d: got %0d (0x%0h), expected %0d..%0d",
                   e.name, cyc, a, a, e.lo, e.hi);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic to_tick();
    while (((now_c() - rel0) % Per) != Per - 1) step(1);
  endtask

  // Leaves the bench in a tick cycle with left target and ramp both settled at 0.
  task automatic settle_left_zero();
    bus.audio_l = 16'h0000;
    to_tick();
    step(1);
    to_tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.audio_l = 16'h7FFF;
    bus.audio_r = 16'h7FFF;
    reset_in    = 1'b0;
    step(1);

    // Reset held with full-scale inputs: outputs stay low, nothing moves.
    for (int k = 0; k < 20; k++) begin
      expect_at(now_c() + k, KSigL, 0, 0, "rst_sigma_l");
      expect_at(now_c() + k, KSigR, 0, 0, "rst_sigma_r");
    end
    expect_at(now_c() + 19, KCnt, 0, 0, "rst_cnt");
    expect_at(now_c() + 19, KTgtL, 0, 0, "rst_target_l");
    step(20);
    checks++;
    if (bus.sigma_l !== 1'b0 || bus.sigma_r !== 1'b0) begin
      errors++;
      $display("FAIL rst_direct_sigma: got %b %b", bus.sigma_l, bus.sigma_r);
    end
    checks++;
    if (dut.cnt_q !== '0) begin
      errors++;
      $display("FAIL rst_direct_cnt: got %0d", dut.cnt_q);
    end

    // Mid-scale after release, plus first-tick placement.
    bus.audio_l = 16'h0000;
    bus.audio_r = 16'h0000;
    reset_in    = 1'b1;
    rel0        = now_c();
    expect_at(rel0 + 254, KTick, 0, 0, "tick_early");
    expect_at(rel0 + 255, KTick, 1, 1, "first_tick");
    expect_at(rel0 + 255, KCnt, 255, 255, "first_tick_cnt");
    expect_at(rel0 + 256, KCnt, 0, 0, "cnt_wrap");
    expect_at(rel0 + 512 + 4095, KOnesL, 2032, 2064, "mid_ones_l", 4096);
    expect_at(rel0 + 512 + 4095, KOnesR, 2032, 2064, "mid_ones_r", 4096);
    step(512 + 4096);

    // Full-scale extremes, then recovery to zero.
    bus.audio_l = 16'h7FFF;
    bus.audio_r = 16'h8000;
    t = now_c();
    expect_at(t + 512 + 4095, KOnesL, 4080, 4096, "max_ones_l", 4096);
    expect_at(t + 512 + 4095, KOnesR, 0, 16, "min_ones_r", 4096);
    step(512 + 4096);
    bus.audio_l = 16'h0000;
    bus.audio_r = 16'h0000;
    t = now_c();
    expect_at(t + 2048 + 4095, KOnesL, 2032, 2064, "recover_ones_l", 4096);
    expect_at(t + 2048 + 4095, KOnesR, 2032, 2064, "recover_ones_r", 4096);
    step(2048 + 4096);

    // Input changes between ticks must not reach target.
    to_tick();
    t = now_c();
    bus.audio_l = 16'h1234;
    bus.audio_r = 16'h5678;
    step(1);
    for (int k = 1; k <= 255; k++) begin
      expect_at(now_c(), KTgtL, 16'h1234, 16'h1234, "hold_target_l");
      if (k % 32 == 1) expect_at(now_c(), KTgtR, 16'h5678, 16'h5678, "hold_target_r");
      bus.audio_l = (k % 2 == 1) ? 16'hFFFF : (16'h0F00 ^ 16'(k));
      bus.audio_r = (k % 2 == 1) ? 16'h8001 : 16'(k);
      step(1);
    end
    expect_at(now_c(), KTick, 1, 1, "hold_tick");
    expect_at(now_c(), KTgtL, 16'h1234, 16'h1234, "hold_target_l_end");
    bus.audio_l = 16'h0ABC;
    bus.audio_r = 16'h0000;
    expect_at(now_c() + 1, KTgtL, 16'h0ABC, 16'h0ABC, "capture_target_l");
    expect_at(now_c() + 1, KTgtR, 0, 0, "capture_target_r");
    expect_at(now_c() + 1, KXL, 16'h1234, 16'h1234, "snap_x_l");
    step(1);

    // Interpolation ramp 0 -> 0x4000 at 64 per clock.
    settle_left_zero();
    t = now_c();
    bus.audio_l = 16'h4000;
    expect_at(t + 1, KTgtL, 16'h4000, 16'h4000, "ramp_target");
    for (int k = 0; k < 256; k++) begin
      expect_at(t + 1 + k, KXL, 64 * k, 64 * k, "ramp_x");
    end
    expect_at(t + 257, KXL, 16'h4000, 16'h4000, "ramp_land");
    expect_at(t + 258, KXL, 16'h4000, 16'h4000, "ramp_no_overshoot");
    step(260);

    // Reset pulse in the middle of a fresh ramp.
    settle_left_zero();
    bus.audio_l = 16'h4000;
    step(101);
    expect_at(now_c(), KXL, 6400, 6400, "pre_reset_x");
    step(1);
    reset_in = 1'b0;
    expect_at(now_c(), KXL, 0, 0, "midrst_x");
    expect_at(now_c(), KTgtL, 0, 0, "midrst_target");
    expect_at(now_c(), KCnt, 0, 0, "midrst_cnt");
    expect_at(now_c(), KSigL, 0, 0, "midrst_sigma_l");
    expect_at(now_c(), KSigR, 0, 0, "midrst_sigma_r");
    step(3);
    checks++;
    if (dut.u_ch_l.x !== '0 || dut.u_ch_l.target_q !== '0) begin
      errors++;
      $display("FAIL midrst_direct_state: x=%0h target=%0h", dut.u_ch_l.x,
               dut.u_ch_l.target_q);
    end
    checks++;
    if (dut.u_ch_l.acc1_q !== '0 || dut.u_ch_l.acc2_q !== '0) begin
      errors++;
      $display("FAIL midrst_direct_acc: acc1=%0h acc2=%0h", dut.u_ch_l.acc1_q,
               dut.u_ch_l.acc2_q);
    end
    checks++;
    if (dut.cnt_q !== '0 || bus.sigma_l !== 1'b0 || bus.sigma_r !== 1'b0) begin
      errors++;
      $display("FAIL midrst_direct_out: cnt=%0d sigma=%b%b", dut.cnt_q, bus.sigma_l,
               bus.sigma_r);
    end
    reset_in = 1'b1;
    rel0 = now_c();
    expect_at(rel0 + 254, KTick, 0, 0, "rel_tick_early");
    expect_at(rel0 + 255, KTick, 1, 1, "rel_tick");
    expect_at(rel0 + 255, KXL, 0, 0, "rel_x_flat");
    expect_at(rel0 + 256, KTgtL, 16'h4000, 16'h4000, "rel_target");
    expect_at(rel0 + 257, KXL, 64, 64, "rel_ramp");
    step(260);

    for (int i = 0; i < 1000 && sb.size() > 0; i++) step(1);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: never reached, expected %0d..%0d at cycle %0d", e.name, e.lo, e.hi, e.at);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_sigma_delta.md
# audio_sigma_delta

Stereo second-order sigma-delta DAC that consumes the 16-bit `audio_l`/`audio_r` words produced by `VirtualToplevel` and drives the board's 1-bit `SIGMA_L`/`SIGMA_R` pins, which are currently tied low. It lives in the board top, clocked by `sysclk`. It samples the input words at a fixed tick rate, linearly interpolates between successive samples, and modulates each channel into a registered pulse-density bitstream.

## Interface
- `WIDTH`, 16: audio sample width; signed two's complement.
- `INTERP_SHIFT`, 8: log2 of the input sampling period in clocks. Each period is also one interpolation ramp.
- `clk`, in, 1: system clock (`sysclk`).
- `reset_in`, in, 1: reset, asynchronous, active-low.
- `audio_l`, in, WIDTH: left sample, signed; level input, may change on any cycle.
- `audio_r`, in, WIDTH: right sample, signed.
- `sigma_l`, out, 1: left pulse-density output, registered.
- `sigma_r`, out, 1: right pulse-density output, registered.

## Operation
- **Tick counter**
  - INTERP_SHIFT-bit free-running counter.
  - `tick` is asserted in the cycle where the counter equals all-ones. It then wraps to 0.
- **Interpolator** (per channel)
  - Registers: `cur` (WIDTH+INTERP_SHIFT+1 bits, fixed point with INTERP_SHIFT fraction bits), `target` (WIDTH), `step` (WIDTH+1, signed).
  - On `tick`, all three updates happen together:
    - `cur` is set to `target` with the fraction cleared (snap, so no drift accumulates).
    - `target` is set to the channel input.
    - `step` is set to input − old `target`, computed in WIDTH+1 bits so the subtraction never overflows.
  - Otherwise `cur` is incremented by `step`, sign-extended.
  - Modulator input `x` = integer part of `cur`, WIDTH bits, signed.
  - Across a full period of 2^INTERP_SHIFT clocks, `cur` advances by exactly `step`. At the next snap it therefore lands on `target`.
- **Modulator** (per channel)
  - Let H = 2^(WIDTH−1). Feedback `fb` = +H when the current output is 1, −H when it is 0.
  - `acc1_n` = sat(`acc1` + x − fb).
  - `acc2_n` = sat(`acc2` + `acc1_n` − fb).
  - `out_n` = (`acc2_n` ≥ 0).
  - Both accumulators are signed WIDTH+4 bits.
  - sat() clamps to the representable range instead of wrapping. This keeps the loop recoverable after full-scale overload.
- The two channels are fully independent and share only the tick counter.

## Timing
- Reset (async assert, synchronous release through `clk`): counter, `cur`, `target`, `step`, `acc1`, `acc2` and both outputs are all 0.
- The first `tick` occurs in the 2^INTERP_SHIFT-th cycle after reset release. The counter goes 0 → all-ones.
- Input to `target`: captured at the tick edge. Input changes between ticks are ignored.
- `target` to `x`: the ramp starts the cycle after the tick. `x` reaches the captured value at the following tick (snap).
- `x` to `sigma_*`: 1 clock, since the outputs are the `out_n` registers.
- Simultaneous tick and large step, e.g. −H → H−1: the step fits in WIDTH+1 bits, so there is no overflow.
- Reset mid-ramp: all state is cleared immediately. No partial ramp survives.
- Input held constant: the output density converges to (x + H) / 2H within ±1/256 over any 4096-cycle window, once 2 tick periods have elapsed.

## Structure
- Shared package `audio_pkg` holds:
  - constants `AUDIO_WIDTH` = 16 and `SD_GUARD_BITS` = 4;
  - the saturating-add function used by the modulator.
- Sub-module `sd_channel` holds one interpolator and one modulator, parameterised by WIDTH and INTERP_SHIFT, with a `tick` input. The top instantiates it twice and owns the shared counter.
- Board top change: replace the constant `SIGMA_L`/`SIGMA_R` drive with `sigma_l`/`sigma_r`. Connect `reset_in` to `reset_button & pll_locked`.

## Test plan
1. **Reset.** Hold `reset_in` = 0 with inputs at 16'h7FFF. Required: `sigma_l` = `sigma_r` = 0 and no toggling for the whole reset period.
2. **Mid-scale.** Inputs = 0, INTERP_SHIFT = 8. After 512 cycles, count ones over 4096 cycles. Required: 2048 ± 16 on both channels.
3. **Extremes.** Left = 16'h7FFF, right = 16'h8000. Required: left ones-density ≥ 4080/4096 and right ≤ 16/4096. Accumulators never exceed their saturation limits, and both channels recover to 2048 ± 16 within 2048 cycles after the inputs return to 0.
4. **Interpolation.** Step the left input 0 → 16'h4000 just before a tick. Required: internal `x` rises monotonically by 64 per clock. It reaches 16'h4000 at the next tick, with no overshoot.
5. **Ignored changes.** Toggle the inputs every cycle between ticks. Required: `target` changes only at tick edges.
6. **Reset mid-ramp.** Pulse `reset_in` low for 3 cycles in the middle of the ramp in test 4. Required: all state is 0 immediately. The next tick lands at exactly 2^INTERP_SHIFT cycles after release.
